register_scoreboard: RTL and testbench
======================================

Name: register_scoreboard

Overview:
- Issue-side hazard controller paired with register_manager.
- Tracks outstanding writes for 32 integer and 32 float registers with per-register counters. Issue of an instruction whose sources, or whose destination counter, are not ready is stalled.
- Counters are cleared by the same four writeback channels (misc, alu, mem, fpu) that feed register_manager, so issue and writeback stay consistent with that block's same-cycle forwarding.

Parameters:
- CNT_W, 2, width of each per-register outstanding-write counter; maximum outstanding writes per register is 2^CNT_W-1.
- TOTAL_W, 8, width of pending_total.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  decode presents an instruction.
- rs_addr  in  5  source 1 register.
- rs_float  in  1  source 1 is a float register.
- rs_used  in  1  source 1 is read.
- rt_addr  in  5  source 2 register.
- rt_float  in  1  source 2 is a float register.
- rt_used  in  1  source 2 is read.
- rd_addr  in  5  destination register.
- rd_float  in  1  destination is a float register.
- rd_write  in  1  instruction writes rd.
- write_enable_{misc,alu,mem,fpu}  in  1 each  writeback valid.
- write_addr_{misc,alu,mem,fpu}  in  5 each  writeback register.
- write_float_{misc,alu,mem,fpu}  in  1 each  writeback targets the float file.
- stall  out  1  combinational; instruction must be held.
- issue_fire  out  1  combinational; issue_valid & ~stall.
- pending_total  out  TOTAL_W  registered; sum of all counters.
- underflow_error  out  1  registered, sticky.

Behaviour:
- State: 64 counters cnt[float][addr], each CNT_W bits. Reset (async) sets all counters to 0, pending_total to 0 and underflow_error to 0. Reset mid-operation discards all outstanding state immediately. Outstanding writebacks that arrive after reset are treated as underflow.
- Integer register 0 is never tracked:
  - issue and writeback to int r0 do not touch counters;
  - int r0 as a source is never a hazard.
  - Float r0 is tracked normally.
- Writeback decrement: wb_hits(f,a) is the number of the four channels with enable=1, matching addr and matching float. It ranges 0..4; duplicates count separately.
- Effective count: eff(f,a) = cnt(f,a) - wb_hits(f,a), saturating at 0. This is the same-cycle bypass: a write landing this cycle is visible to the reader through register_manager forwarding.
- stall = issue_valid & (haz_rs | haz_rt | haz_rd), where:
  - haz_rs = rs_used & eff(rs_float,rs_addr)!=0;
  - haz_rt = rt_used & eff(rt_float,rt_addr)!=0;
  - haz_rd = rd_write & cnt(rd_float,rd_addr)==max. Uses the raw count, no bypass.
  - WAW to a non-full counter does not stall.
- Next-state per counter: cnt' = cnt - wb_hits + (issue_fire & rd_write & match rd).
  - If the subtraction would go below 0 (net of a same-cycle increment), the counter goes to 0 and underflow_error sets. It stays set until reset.
- Simultaneous issue and writeback to the same register: both apply in one cycle (net zero for one of each).
- pending_total' = pending_total + inc - sum of decrements actually applied, computed with the clamped amounts. It must always equal the sum of counters.
- Latency: stall and issue_fire are combinational from the inputs and current state. Counter, total and error updates are visible one cycle after the edge.
- No handshake state: decode holds its inputs while stall=1. The block does not latch issue requests.

Test Plan:
- Reset, then issue rd=int r5 write → next cycle pending_total=1. Issue rs=r5 used → stall=1. Assert write_enable_alu, addr 5, float 0 in the same cycle → stall=0, issue_fire=1, next cycle pending_total=0.
- Float vs int isolation: pending write on float f3. Issue reading int r3 → stall=0. Issue reading float f3 → stall=1.
- Saturation: three issues to int r7 with no writebacks → cnt=3, pending_total=3. Fourth issue with rd=r7 → stall=1. One mem writeback to r7 → next cycle the fourth issue fires.
- Multi-port writeback: cnt(int r9)=2. misc and fpu both write r9 in one cycle → next cycle cnt=0, pending_total drops by 2, no error.
- Underflow and r0: alu writeback to int r4 with cnt=0 → underflow_error=1 next cycle and stays 1. Issue with rd=int r0 → pending_total unchanged. Reading int r0 → stall=0.
- Async reset mid-operation: pending_total=5. Pulse reset between clock edges → pending_total=0, underflow_error=0, stall=0 immediately without a clock edge.

Source files
------------

// File: rtl/register_scoreboard.sv
// Issue-side hazard scoreboard: per-register outstanding-write counters for 32 int + 32 float regs.
// stall/issue_fire are combinational; counters, total and error update one cycle after the edge.
module register_scoreboard #(
  parameter int CNT_W   = 2,
  parameter int TOTAL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               issue_valid,
  input  logic [4:0]         rs_addr,
  input  logic               rs_float,
  input  logic               rs_used,
  input  logic [4:0]         rt_addr,
  input  logic               rt_float,
  input  logic               rt_used,
  input  logic [4:0]         rd_addr,
  input  logic               rd_float,
  input  logic               rd_write,
  input  logic               write_enable_misc,
  input  logic [4:0]         write_addr_misc,
  input  logic               write_float_misc,
  input  logic               write_enable_alu,
  input  logic [4:0]         write_addr_alu,
  input  logic               write_float_alu,
  input  logic               write_enable_mem,
  input  logic [4:0]         write_addr_mem,
  input  logic               write_float_mem,
  input  logic               write_enable_fpu,
  input  logic [4:0]         write_addr_fpu,
  input  logic               write_float_fpu,
  output logic               stall,
  output logic               issue_fire,
  output logic [TOTAL_W-1:0] pending_total,
  output logic               underflow_error
);

  localparam int AW = (CNT_W + 1 > 3) ? CNT_W + 1 : 3;
  localparam int SW = AW + 6;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]   r_cnt [2][32];
  logic [TOTAL_W-1:0] r_pending_total;
  logic               r_underflow;

  logic [2:0]         w_hits    [2][32];
  logic [CNT_W-1:0]   w_cnt_nxt [2][32];
  logic [AW-1:0]      w_avail;
  logic [AW-1:0]      w_need;
  logic [SW-1:0]      w_dec_sum;
  logic               w_uf;
  logic               w_haz_rs;
  logic               w_haz_rt;
  logic               w_haz_rd;
  logic               w_rd_tracked;
  logic               w_inc;
  logic               w_stall;

  // Writeback hits per register; int r0 is never tracked, so it never sees a hit.
  always_comb begin
    for (int f = 0; f < 2; f++) begin
      for (int a = 0; a < 32; a++) begin
        w_hits[f][a] =
            3'(write_enable_misc && write_addr_misc == 5'(a) && write_float_misc == 1'(f)) +
            3'(write_enable_alu  && write_addr_alu  == 5'(a) && write_float_alu  == 1'(f)) +
            3'(write_enable_mem  && write_addr_mem  == 5'(a) && write_float_mem  == 1'(f)) +
            3'(write_enable_fpu  && write_addr_fpu  == 5'(a) && write_float_fpu  == 1'(f));
        if (f == 0 && a == 0) begin
          w_hits[f][a] = 3'd0;
        end
      end
    end
  end

  // Sources see same-cycle writebacks (eff > 0 iff cnt > hits); destination uses the raw count.
  assign w_haz_rs = rs_used &
                    (AW'(r_cnt[rs_float][rs_addr]) > AW'(w_hits[rs_float][rs_addr]));
  assign w_haz_rt = rt_used &
                    (AW'(r_cnt[rt_float][rt_addr]) > AW'(w_hits[rt_float][rt_addr]));
  assign w_haz_rd = rd_write & (r_cnt[rd_float][rd_addr] == CNT_MAX);

  assign w_stall      = issue_valid & (w_haz_rs | w_haz_rt | w_haz_rd);
  assign stall        = w_stall;
  assign issue_fire   = issue_valid & ~w_stall;
  assign w_rd_tracked = rd_float | (rd_addr != 5'd0);
  assign w_inc        = issue_valid & ~w_stall & rd_write & w_rd_tracked;

  // Decrements are clamped against count plus any same-cycle increment; the clamped amount feeds the total.
  always_comb begin
    w_dec_sum = '0;
    w_uf      = 1'b0;
    w_avail   = '0;
    w_need    = '0;
    for (int f = 0; f < 2; f++) begin
      for (int a = 0; a < 32; a++) begin
        w_avail = AW'(r_cnt[f][a]) +
                  AW'(w_inc && rd_float == 1'(f) && rd_addr == 5'(a));
        w_need  = AW'(w_hits[f][a]);
        if (w_need > w_avail) begin
          w_cnt_nxt[f][a] = '0;
          w_uf            = 1'b1;
          w_dec_sum       = w_dec_sum + SW'(w_avail);
        end else begin
          w_cnt_nxt[f][a] = CNT_W'(w_avail - w_need);
          w_dec_sum       = w_dec_sum + SW'(w_need);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int f = 0; f < 2; f++) begin
        for (int a = 0; a < 32; a++) begin
          r_cnt[f][a] <= '0;
        end
      end
      r_pending_total <= '0;
      r_underflow     <= 1'b0;
    end else begin
      r_cnt           <= w_cnt_nxt;
      r_pending_total <= r_pending_total + TOTAL_W'(w_inc) - TOTAL_W'(w_dec_sum);
      r_underflow     <= r_underflow | w_uf;
    end
  end

  assign pending_total   = r_pending_total;
  assign underflow_error = r_underflow;

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed bench for register_scoreboard with hand-computed expectations.
module tb_register_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid;
  logic [4:0] rs_addr, rt_addr, rd_addr;
  logic       rs_float, rs_used, rt_float, rt_used, rd_float, rd_write;
  logic       write_enable_misc, write_float_misc;
  logic [4:0] write_addr_misc;
  logic       write_enable_alu, write_float_alu;
  logic [4:0] write_addr_alu;
  logic       write_enable_mem, write_float_mem;
  logic [4:0] write_addr_mem;
  logic       write_enable_fpu, write_float_fpu;
  logic [4:0] write_addr_fpu;
  logic       stall, issue_fire, underflow_error;
  logic [7:0] pending_total;

  int n_tests = 0;
  int n_fail  = 0;

  register_scoreboard #(.CNT_W(2), .TOTAL_W(8)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .rs_addr(rs_addr), .rs_float(rs_float), .rs_used(rs_used),
    .rt_addr(rt_addr), .rt_float(rt_float), .rt_used(rt_used),
    .rd_addr(rd_addr), .rd_float(rd_float), .rd_write(rd_write),
    .write_enable_misc(write_enable_misc), .write_addr_misc(write_addr_misc), .write_float_misc(write_float_misc),
    .write_enable_alu(write_enable_alu), .write_addr_alu(write_addr_alu), .write_float_alu(write_float_alu),
    .write_enable_mem(write_enable_mem), .write_addr_mem(write_addr_mem), .write_float_mem(write_float_mem),
    .write_enable_fpu(write_enable_fpu), .write_addr_fpu(write_addr_fpu), .write_float_fpu(write_float_fpu),
    .stall(stall), .issue_fire(issue_fire), .pending_total(pending_total),
    .underflow_error(underflow_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 0;
    rs_addr = 0; rs_float = 0; rs_used = 0;
    rt_addr = 0; rt_float = 0; rt_used = 0;
    rd_addr = 0; rd_float = 0; rd_write = 0;
    write_enable_misc = 0; write_addr_misc = 0; write_float_misc = 0;
    write_enable_alu  = 0; write_addr_alu  = 0; write_float_alu  = 0;
    write_enable_mem  = 0; write_addr_mem  = 0; write_float_mem  = 0;
    write_enable_fpu  = 0; write_addr_fpu  = 0; write_float_fpu  = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_rd(input logic [4:0] a, input logic f);
    idle();
    issue_valid = 1; rd_addr = a; rd_float = f; rd_write = 1;
  endtask

  task automatic read_rs(input logic [4:0] a, input logic f);
    idle();
    issue_valid = 1; rs_addr = a; rs_float = f; rs_used = 1;
  endtask

  initial begin
    idle();
    reset = 1;
    #12;
    chk("rst_total", 32'(pending_total), 0);
    chk("rst_err", 32'(underflow_error), 0);
    chk("rst_stall", 32'(stall), 0);
    reset = 0;
    tick();

    // Basic RAW with same-cycle bypass
    issue_rd(5, 0); #1;
    chk("r5_issue_fire", 32'(issue_fire), 1);
    tick(); idle(); #1;
    chk("r5_total1", 32'(pending_total), 1);
    read_rs(5, 0); #1;
    chk("r5_raw_stall", 32'(stall), 1);
    chk("r5_raw_nofire", 32'(issue_fire), 0);
    write_enable_alu = 1; write_addr_alu = 5; write_float_alu = 0; #1;
    chk("r5_bypass_stall", 32'(stall), 0);
    chk("r5_bypass_fire", 32'(issue_fire), 1);
    tick(); idle(); #1;
    chk("r5_total0", 32'(pending_total), 0);

    // Float vs int isolation
    issue_rd(3, 1); tick(); idle(); #1;
    chk("f3_total", 32'(pending_total), 1);
    read_rs(3, 0); #1;
    chk("int_r3_nostall", 32'(stall), 0);
    read_rs(3, 1); #1;
    chk("f3_rs_stall", 32'(stall), 1);
    idle(); issue_valid = 1; rt_addr = 3; rt_float = 1; rt_used = 1; #1;
    chk("f3_rt_stall", 32'(stall), 1);
    idle(); write_enable_fpu = 1; write_addr_fpu = 3; write_float_fpu = 1;
    tick(); idle(); #1;
    chk("f3_drained", 32'(pending_total), 0);

    // Saturation on int r7
    for (int i = 0; i < 3; i++) begin
      issue_rd(7, 0); tick();
    end
    idle(); #1;
    chk("r7_total3", 32'(pending_total), 3);
    issue_rd(7, 0); #1;
    chk("r7_full_stall", 32'(stall), 1);
    write_enable_mem = 1; write_addr_mem = 7; write_float_mem = 0; #1;
    chk("r7_full_raw_stall", 32'(stall), 1);
    tick(); issue_rd(7, 0); #1;
    chk("r7_after_wb_total", 32'(pending_total), 2);
    chk("r7_fourth_fire", 32'(issue_fire), 1);
    tick(); idle(); #1;
    chk("r7_total_back3", 32'(pending_total), 3);
    write_enable_misc = 1; write_addr_misc = 7;
    write_enable_alu  = 1; write_addr_alu  = 7;
    write_enable_mem  = 1; write_addr_mem  = 7;
    tick(); idle(); #1;
    chk("r7_triple_wb", 32'(pending_total), 0);
    chk("r7_no_err", 32'(underflow_error), 0);

    // Multi-port writeback on r9, with partial bypass on rt
    issue_rd(9, 0); tick(); issue_rd(9, 0); tick(); idle(); #1;
    chk("r9_total2", 32'(pending_total), 2);
    issue_valid = 1; rt_addr = 9; rt_used = 1;
    write_enable_misc = 1; write_addr_misc = 9; #1;
    chk("r9_partial_bypass", 32'(stall), 1);
    write_enable_fpu = 1; write_addr_fpu = 9; write_float_fpu = 0; #1;
    chk("r9_full_bypass", 32'(stall), 0);
    issue_valid = 0;
    tick(); idle(); #1;
    chk("r9_total0", 32'(pending_total), 0);
    chk("r9_no_err", 32'(underflow_error), 0);

    // Simultaneous issue and writeback to the same register
    issue_rd(5, 0); tick();
    issue_rd(5, 0); write_enable_alu = 1; write_addr_alu = 5; #1;
    chk("r5_net_fire", 32'(issue_fire), 1);
    tick(); idle(); #1;
    chk("r5_net_zero", 32'(pending_total), 1);
    write_enable_alu = 1; write_addr_alu = 5; tick(); idle(); #1;
    chk("r5_cleared", 32'(pending_total), 0);

    // int r0 untracked, float r0 tracked
    issue_rd(0, 0); tick(); idle(); #1;
    chk("r0_issue_total", 32'(pending_total), 0);
    read_rs(0, 0); #1;
    chk("r0_read_nostall", 32'(stall), 0);
    idle(); write_enable_alu = 1; write_addr_alu = 0; tick(); idle(); #1;
    chk("r0_wb_no_err", 32'(underflow_error), 0);
    issue_rd(0, 1); tick(); idle(); #1;
    chk("f0_total", 32'(pending_total), 1);
    read_rs(0, 1); #1;
    chk("f0_stall", 32'(stall), 1);
    idle(); write_enable_fpu = 1; write_addr_fpu = 0; write_float_fpu = 1;
    tick(); idle(); #1;
    chk("f0_drained", 32'(pending_total), 0);

    // Underflow is sticky
    write_enable_alu = 1; write_addr_alu = 4; tick(); idle(); #1;
    chk("uf_set", 32'(underflow_error), 1);
    chk("uf_total", 32'(pending_total), 0);
    tick(); #1;
    chk("uf_sticky", 32'(underflow_error), 1);

    // Async reset mid-operation
    for (int i = 0; i < 3; i++) begin
      issue_rd(10, 0); tick();
    end
    for (int i = 0; i < 2; i++) begin
      issue_rd(11, 0); tick();
    end
    read_rs(10, 0); #1;
    chk("pre_rst_total5", 32'(pending_total), 5);
    chk("pre_rst_stall", 32'(stall), 1);
    reset = 1; #1;
    chk("arst_total", 32'(pending_total), 0);
    chk("arst_err", 32'(underflow_error), 0);
    chk("arst_stall", 32'(stall), 0);
    reset = 0;
    idle(); write_enable_mem = 1; write_addr_mem = 10;
    tick(); idle(); #1;
    chk("post_rst_wb_uf", 32'(underflow_error), 1);
    chk("post_rst_total", 32'(pending_total), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
